hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core. Generates stall, flush and bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and EX-stage forwarding selects.
- Runs a small FSM that freezes the pipeline during multi-cycle data-memory accesses, with timeout detection, and keeps a stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: stall/flush/bubble
// generation, EX forwarding selects, data-memory wait FSM with timeout and a stall counter.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [4:0]       rs_e,
  input  logic [4:0]       rt_e,
  input  logic [4:0]       writereg_e,
  input  logic             RegWrite_e,
  input  logic             MemtoReg_e,
  input  logic [4:0]       writereg_m,
  input  logic             RegWrite_m,
  input  logic [4:0]       writereg_w,
  input  logic             RegWrite_w,
  input  logic             branch_taken_d,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             bubble_w,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       state_dbg
);

  // Memory handshake: dmem_req/dmem_ready are sampled together each cycle; an
  // access completes in the cycle dmem_ready=1, which is never a stall cycle.

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_t;

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic mem_wait;
  logic load_use;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       we_m,
    input logic [4:0] wr_m,
    input logic       we_w,
    input logic [4:0] wr_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 5'd0) begin
      if (we_m && (wr_m == src))      sel = 2'b10;
      else if (we_w && (wr_w == src)) sel = 2'b01;
    end
    return sel;
  endfunction

  assign mem_wait = !dmem_ready &&
                    ((state_q == S_MEM_WAIT) || ((state_q == S_RUN) && dmem_req));
  assign load_use = MemtoReg_e && RegWrite_e && (writereg_e != 5'd0) &&
                    ((writereg_e == rs_d) || (writereg_e == rt_d));

  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    bubble_w = 1'b0;
    if (rst_n) begin
      if ((state_q == S_ERR) || mem_wait) begin
        // Whole pipe frozen; a taken branch stays in decode and is flushed later.
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        stall_m  = 1'b1;
        bubble_w = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else if (branch_taken_d) begin
        flush_d = 1'b1;
      end
    end
  end

  assign fwd_a_e = fwd_sel(rs_e, RegWrite_m, writereg_m, RegWrite_w, writereg_w);
  assign fwd_b_e = fwd_sel(rt_e, RegWrite_m, writereg_m, RegWrite_w, writereg_w);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      S_RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_d    = S_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d   = S_ERR;
            mem_err_d = 1'b1;
          end
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
    stall_cnt_d = stall_cnt_q;
    if (stall_f && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_cnt_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vectors, a behavioural model compared every
// cycle on the falling edge, and hand-computed literal expectations.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 16;
  localparam int M_RUN = 0, M_WAIT = 1, M_ERR = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic        RegWrite_e, MemtoReg_e, RegWrite_m, RegWrite_w;
  logic        branch_taken_d, dmem_req, dmem_ready;
  logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w;
  logic [1:0]  fwd_a_e, fwd_b_e, state_dbg;
  logic        mem_err;
  logic [31:0] stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .RegWrite_e(RegWrite_e), .MemtoReg_e(MemtoReg_e),
    .writereg_m(writereg_m), .RegWrite_m(RegWrite_m),
    .writereg_w(writereg_w), .RegWrite_w(RegWrite_w),
    .branch_taken_d(branch_taken_d), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .bubble_w(bubble_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_mode   = M_RUN;
  int          m_waited = 0;
  logic        m_err    = 1'b0;
  logic [31:0] m_stalls = '0;

  logic e_stall_f, e_stall_d, e_stall_e, e_stall_m, e_flush_d, e_flush_e, e_bubble_w;
  logic [1:0] e_fwd_a, e_fwd_b;

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (RegWrite_m && writereg_m == src) return 2'b10;
    if (RegWrite_w && writereg_w == src) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    logic frozen, lu;
    e_stall_f = 0; e_stall_d = 0; e_stall_e = 0; e_stall_m = 0;
    e_flush_d = 0; e_flush_e = 0; e_bubble_w = 0;
    frozen = (m_mode == M_ERR) ||
             (!dmem_ready && (m_mode == M_WAIT || (m_mode == M_RUN && dmem_req)));
    lu = MemtoReg_e && RegWrite_e && writereg_e != 0 &&
         (writereg_e == rs_d || writereg_e == rt_d);
    if (rst_n === 1'b1) begin
      if (frozen) begin
        e_stall_f = 1; e_stall_d = 1; e_stall_e = 1; e_stall_m = 1; e_bubble_w = 1;
      end else if (lu) begin
        e_stall_f = 1; e_stall_d = 1; e_flush_e = 1;
      end else if (branch_taken_d) begin
        e_flush_d = 1;
      end
    end
    e_fwd_a = model_fwd(rs_e);
    e_fwd_b = model_fwd(rt_e);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_RUN; m_waited <= 0; m_err <= 1'b0; m_stalls <= '0;
    end else begin
      if (e_stall_f && m_stalls != 32'hFFFF_FFFF) m_stalls <= m_stalls + 1;
      if (m_mode == M_RUN && dmem_req && !dmem_ready) begin
        m_mode <= M_WAIT; m_waited <= 0;
      end else if (m_mode == M_WAIT) begin
        if (dmem_ready) begin
          m_mode <= M_RUN; m_waited <= 0;
        end else begin
          m_waited <= m_waited + 1;
          if (m_waited + 1 >= TIMEOUT) begin
            m_mode <= M_ERR; m_err <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_stall_f", 32'(stall_f), 32'(e_stall_f));
    chk("cmp_stall_d", 32'(stall_d), 32'(e_stall_d));
    chk("cmp_stall_e", 32'(stall_e), 32'(e_stall_e));
    chk("cmp_stall_m", 32'(stall_m), 32'(e_stall_m));
    chk("cmp_flush_d", 32'(flush_d), 32'(e_flush_d));
    chk("cmp_flush_e", 32'(flush_e), 32'(e_flush_e));
    chk("cmp_bubble_w", 32'(bubble_w), 32'(e_bubble_w));
    chk("cmp_fwd_a", 32'(fwd_a_e), 32'(e_fwd_a));
    chk("cmp_fwd_b", 32'(fwd_b_e), 32'(e_fwd_b));
    chk("cmp_mem_err", 32'(mem_err), 32'(m_err));
    chk("cmp_stall_cycles", stall_cycles, m_stalls);
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    writereg_e = 0; writereg_m = 0; writereg_w = 0;
    RegWrite_e = 0; MemtoReg_e = 0; RegWrite_m = 0; RegWrite_w = 0;
    branch_taken_d = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [4:0] wr);
    writereg_e = wr; MemtoReg_e = 1; RegWrite_e = 1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    clear_inputs();
    set_load(5'd5); rs_d = 5'd5;
    dmem_req = 1;
    repeat (2) @(negedge clk);
    chk("rst_stall_f", 32'(stall_f), 0);
    chk("rst_flush_e", 32'(flush_e), 0);
    chk("rst_stall_cycles", stall_cycles, 0);

    next_cycle(); rst_n = 1'b1; clear_inputs();
    @(negedge clk);

    // load-use: exactly one stall cycle, then MEM forwarding covers the load
    next_cycle(); set_load(5'd5); rs_d = 5'd5;
    @(negedge clk);
    chk("lu_stall_f", 32'(stall_f), 1);
    chk("lu_stall_d", 32'(stall_d), 1);
    chk("lu_flush_e", 32'(flush_e), 1);
    chk("lu_stall_e", 32'(stall_e), 0);
    next_cycle(); clear_inputs(); writereg_m = 5'd5; RegWrite_m = 1; rs_e = 5'd5;
    @(negedge clk);
    chk("lu_after_stall_f", 32'(stall_f), 0);
    chk("lu_after_fwd_a", 32'(fwd_a_e), 32'b10);
    chk("lu_stall_cycles", stall_cycles, 1);

    // forwarding priority
    next_cycle(); clear_inputs();
    writereg_m = 5'd7; writereg_w = 5'd7; RegWrite_m = 1; RegWrite_w = 1;
    rs_e = 5'd7; rt_e = 5'd0;
    @(negedge clk);
    chk("fwd_mem_a", 32'(fwd_a_e), 32'b10);
    chk("fwd_zero_b", 32'(fwd_b_e), 32'b00);
    next_cycle(); RegWrite_m = 0; rt_e = 5'd7;
    @(negedge clk);
    chk("fwd_wb_a", 32'(fwd_a_e), 32'b01);
    chk("fwd_wb_b", 32'(fwd_b_e), 32'b01);

    // memory wait: 3 stalled cycles, branch held then flushed on ready
    next_cycle(); clear_inputs(); dmem_req = 1;
    @(negedge clk);
    chk("mw0_stall_f", 32'(stall_f), 1);
    chk("mw0_bubble_w", 32'(bubble_w), 1);
    next_cycle(); branch_taken_d = 1;
    @(negedge clk);
    chk("mw1_stall_m", 32'(stall_m), 1);
    chk("mw1_flush_d", 32'(flush_d), 0);
    next_cycle();
    @(negedge clk);
    chk("mw2_stall_e", 32'(stall_e), 1);
    next_cycle(); dmem_ready = 1;
    @(negedge clk);
    chk("mw_ready_stall_f", 32'(stall_f), 0);
    chk("mw_ready_bubble_w", 32'(bubble_w), 0);
    chk("mw_ready_flush_d", 32'(flush_d), 1);
    next_cycle(); dmem_req = 0; dmem_ready = 0; branch_taken_d = 0;
    @(negedge clk);
    chk("mw_state_run", 32'(state_dbg), 0);
    chk("mw_stall_cycles", stall_cycles, 4);
    chk("mw_flush_d_off", 32'(flush_d), 0);

    // zero-wait access never stalls
    next_cycle(); dmem_req = 1; dmem_ready = 1;
    @(negedge clk);
    chk("zw_stall_f", 32'(stall_f), 0);

    // load-use on rt with a taken branch: flush_d suppressed
    next_cycle(); clear_inputs(); set_load(5'd9); rt_d = 5'd9; branch_taken_d = 1;
    @(negedge clk);
    chk("lub_flush_e", 32'(flush_e), 1);
    chk("lub_flush_d", 32'(flush_d), 0);
    chk("lub_stall_d", 32'(stall_d), 1);

    // register $0 guard
    next_cycle(); clear_inputs(); set_load(5'd0); rs_d = 5'd0;
    RegWrite_m = 1; writereg_m = 5'd0; RegWrite_w = 1; writereg_w = 5'd0; rs_e = 5'd0;
    @(negedge clk);
    chk("r0_stall_f", 32'(stall_f), 0);
    chk("r0_fwd_a", 32'(fwd_a_e), 32'b00);
    chk("r0_stall_cycles", stall_cycles, 5);

    // timeout: 1 RUN stall cycle + TIMEOUT wait cycles, then ERR
    next_cycle(); clear_inputs(); dmem_req = 1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      if (k == TIMEOUT) chk("to_err_not_yet", 32'(mem_err), 0);
      if (k == TIMEOUT + 1) chk("to_err_set", 32'(mem_err), 1);
      if (k == 19) chk("to_stall_f", 32'(stall_f), 1);
    end
    next_cycle(); dmem_req = 0; dmem_ready = 1; set_load(5'd3); rs_d = 5'd3;
    @(negedge clk);
    chk("err_sticky_stall", 32'(stall_f), 1);
    chk("err_flush_e", 32'(flush_e), 0);
    chk("err_mem_err", 32'(mem_err), 1);
    chk("err_stall_cycles", stall_cycles, 25);

    // asynchronous reset mid-cycle clears outputs at once
    next_cycle(); #2 rst_n = 1'b0; #1;
    chk("arst_stall_f", 32'(stall_f), 0);
    chk("arst_bubble_w", 32'(bubble_w), 0);
    chk("arst_mem_err", 32'(mem_err), 0);
    chk("arst_stall_cycles", stall_cycles, 0);
    @(negedge clk);
    next_cycle(); rst_n = 1'b1; clear_inputs();
    @(negedge clk);
    chk("post_rst_state", 32'(state_dbg), 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
